// File: rtl/char_slot_scheduler.sv
// Falling-character slot table for the typing game. Admits spawned characters
// into free slots, advances them on frame ticks, resolves keypresses, keeps the
// score and the sticky game-over flag. All table work happens in SLOTS-cycle
// sweeps, one slot per cycle; the renderer reads slots combinationally.
module char_slot_scheduler #(
    parameter int unsigned SLOTS       = 16,
    parameter int unsigned LOWER_BOUND = 480,
    parameter int unsigned SCORE_MAX   = 99
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic                     spawn_valid_i,
    output logic                     spawn_ready_o,
    input  logic [7:0]               spawn_ch_i,
    input  logic [9:0]               spawn_x_i,
    input  logic [2:0]               spawn_speed_i,
    input  logic                     frame_tick_i,
    input  logic                     key_valid_i,
    input  logic [7:0]               key_ascii_i,
    input  logic [$clog2(SLOTS)-1:0] rd_idx_i,
    output logic                     rd_active_o,
    output logic [7:0]               rd_ch_o,
    output logic [9:0]               rd_x_o,
    output logic [9:0]               rd_y_o,
    output logic [7:0]               score_o,
    output logic                     gameover_o,
    output logic                     busy_o
);

    localparam int unsigned     IdxW     = $clog2(SLOTS);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(SLOTS - 1);
    localparam logic [9:0]      LowerY   = 10'(LOWER_BOUND);
    localparam logic [7:0]      ScoreTop = 8'(SCORE_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSpawn,
        StMatch,
        StMove
    } state_e;

    // Slot table
    logic [SLOTS-1:0]       active_q;
    logic [SLOTS-1:0][7:0]  ch_q;
    logic [SLOTS-1:0][9:0]  x_q;
    logic [SLOTS-1:0][9:0]  y_q;
    logic [SLOTS-1:0][2:0]  sp_q;

    // Sweep control
    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    // Latched spawn offer and whether it has been placed this sweep
    logic [7:0]        off_ch_q, off_ch_d;
    logic [9:0]        off_x_q, off_x_d;
    logic [2:0]        off_sp_q, off_sp_d;
    logic              done_q, done_d;

    // Match search state
    logic [7:0]        key_q, key_d;
    logic              best_vld_q, best_vld_d;
    logic [IdxW-1:0]   best_idx_q, best_idx_d;
    logic [9:0]        best_y_q, best_y_d;

    // One-deep pending events
    logic              kp_q, kp_d;
    logic [7:0]        kp_ascii_q, kp_ascii_d;
    logic              tp_q, tp_d;

    logic [7:0]        score_q, score_d;
    logic              go_q, go_d;

    // Single table write port
    logic              wr_en;
    logic              wr_act_only;
    logic [IdxW-1:0]   wr_idx;
    logic              wr_act;
    logic [7:0]        wr_ch;
    logic [9:0]        wr_x;
    logic [9:0]        wr_y;
    logic [2:0]        wr_sp;

    logic              accept;
    logic              spawn_fire;
    logic              key_now;
    logic [7:0]        key_sel;
    logic              tick_now;
    logic              last;
    logic              cur_act;
    logic [7:0]        cur_ch;
    logic [9:0]        cur_x;
    logic [9:0]        cur_y;
    logic [2:0]        cur_sp;
    logic [10:0]       y_sum;
    logic [9:0]        y_new;
    logic              hit;
    logic              better;
    logic              win_vld;
    logic [IdxW-1:0]   win_idx;

    // Input gating, slot under the sweep pointer and per-slot arithmetic
    always_comb begin
        accept        = en_i & ~go_q;
        spawn_ready_o = (state_q == StIdle) & en_i & ~go_q & ~clear_i & ~rst_i;
        spawn_fire    = spawn_valid_i & spawn_ready_o;
        key_now       = accept & (key_valid_i | kp_q);
        key_sel       = key_valid_i ? key_ascii_i : kp_ascii_q;
        tick_now      = accept & (frame_tick_i | tp_q);
        last          = (idx_q == LastIdx);

        cur_act = active_q[idx_q];
        cur_ch  = ch_q[idx_q];
        cur_x   = x_q[idx_q];
        cur_y   = y_q[idx_q];
        cur_sp  = sp_q[idx_q];

        y_sum = {1'b0, cur_y} + {8'b0, cur_sp};
        y_new = y_sum[10] ? 10'h3FF : y_sum[9:0];

        // Strict compare keeps the lowest index on equal y
        hit     = cur_act & (cur_ch == key_q);
        better  = hit & (~best_vld_q | (cur_y > best_y_q));
        win_vld = best_vld_q | hit;
        win_idx = better ? idx_q : best_idx_q;
    end

    // Next-state: sweep sequencing, table writes, pending latches, score
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        off_ch_d    = off_ch_q;
        off_x_d     = off_x_q;
        off_sp_d    = off_sp_q;
        done_d      = done_q;
        key_d       = key_q;
        best_vld_d  = best_vld_q;
        best_idx_d  = best_idx_q;
        best_y_d    = best_y_q;
        score_d     = score_q;
        go_d        = go_q;
        wr_en       = 1'b0;
        wr_act_only = 1'b0;
        wr_idx      = idx_q;
        wr_act      = 1'b0;
        wr_ch       = off_ch_q;
        wr_x        = off_x_q;
        wr_y        = '0;
        wr_sp       = off_sp_q;

        if (accept) begin
            kp_d       = kp_q | key_valid_i;
            kp_ascii_d = key_valid_i ? key_ascii_i : kp_ascii_q;
            tp_d       = tp_q | frame_tick_i;
        end else begin
            kp_d       = 1'b0;
            kp_ascii_d = kp_ascii_q;
            tp_d       = 1'b0;
        end

        if (clear_i) begin
            state_d = StClear;
            idx_d   = '0;
            score_d = '0;
            go_d    = 1'b0;
            kp_d    = 1'b0;
            tp_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (spawn_fire) begin
                        off_ch_d = spawn_ch_i;
                        off_x_d  = spawn_x_i;
                        off_sp_d = spawn_speed_i;
                        done_d   = 1'b0;
                        state_d  = StSpawn;
                        idx_d    = '0;
                    end else if (key_now) begin
                        key_d      = key_sel;
                        kp_d       = 1'b0;
                        best_vld_d = 1'b0;
                        state_d    = StMatch;
                        idx_d      = '0;
                    end else if (tick_now) begin
                        tp_d    = 1'b0;
                        state_d = StMove;
                        idx_d   = '0;
                    end
                end
                StClear: begin
                    wr_en  = 1'b1;
                    wr_act = 1'b0;
                    wr_ch  = '0;
                    wr_x   = '0;
                    wr_y   = '0;
                    wr_sp  = '0;
                end
                StSpawn: begin
                    if (!done_q && !cur_act) begin
                        wr_en  = 1'b1;
                        wr_act = 1'b1;
                        done_d = 1'b1;
                    end
                end
                StMatch: begin
                    if (better) begin
                        best_vld_d = 1'b1;
                        best_idx_d = idx_q;
                        best_y_d   = cur_y;
                    end
                    if (last && win_vld) begin
                        wr_en       = 1'b1;
                        wr_act_only = 1'b1;
                        wr_idx      = win_idx;
                        wr_act      = 1'b0;
                        if (score_q < ScoreTop) begin
                            score_d = score_q + 8'd1;
                        end
                    end
                end
                StMove: begin
                    if (cur_act) begin
                        wr_en  = 1'b1;
                        wr_act = 1'b1;
                        wr_ch  = cur_ch;
                        wr_x   = cur_x;
                        wr_y   = y_new;
                        wr_sp  = cur_sp;
                        if (y_new >= LowerY) begin
                            go_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (state_q != StIdle) begin
                if (last) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    // Slot table storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= '0;
            ch_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sp_q     <= '0;
        end else if (wr_en) begin
            active_q[wr_idx] <= wr_act;
            if (!wr_act_only) begin
                ch_q[wr_idx] <= wr_ch;
                x_q[wr_idx]  <= wr_x;
                y_q[wr_idx]  <= wr_y;
                sp_q[wr_idx] <= wr_sp;
            end
        end
    end

    // Control, latches, score and game-over registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            off_ch_q   <= '0;
            off_x_q    <= '0;
            off_sp_q   <= '0;
            done_q     <= 1'b0;
            key_q      <= '0;
            best_vld_q <= 1'b0;
            best_idx_q <= '0;
            best_y_q   <= '0;
            kp_q       <= 1'b0;
            kp_ascii_q <= '0;
            tp_q       <= 1'b0;
            score_q    <= '0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            off_ch_q   <= off_ch_d;
            off_x_q    <= off_x_d;
            off_sp_q   <= off_sp_d;
            done_q     <= done_d;
            key_q      <= key_d;
            best_vld_q <= best_vld_d;
            best_idx_q <= best_idx_d;
            best_y_q   <= best_y_d;
            kp_q       <= kp_d;
            kp_ascii_q <= kp_ascii_d;
            tp_q       <= tp_d;
            score_q    <= score_d;
            go_q       <= go_d;
        end
    end

    // Renderer read port and status outputs
    always_comb begin
        rd_active_o = active_q[rd_idx_i];
        rd_ch_o     = ch_q[rd_idx_i];
        rd_x_o      = x_q[rd_idx_i];
        rd_y_o      = y_q[rd_idx_i];
        score_o     = score_q;
        gameover_o  = go_q;
        busy_o      = (state_q != StIdle);
    end

endmodule
